// File: rtl/aurora_pkg.sv
// Shared Aurora 8B/10B lane definitions: ordered-set encoding, K-characters,
// fixed symbol words and the idle-byte selector.
package aurora_pkg;

  localparam int AXI_DATA_SIZE = 32;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    SCP  = 2'd1,
    ECP  = 2'd2,
    I    = 2'd3
  } ordered_sets_e;

  typedef enum logic {
    OUT_FRAME = 1'b0,
    IN_FRAME  = 1'b1
  } frame_state_e;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_0 = 8'h1C;
  localparam logic [7:0] K28_3 = 8'h7C;
  localparam logic [7:0] K28_2 = 8'h5C;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;
  localparam logic [7:0] K23_7 = 8'hF7;

  localparam logic [31:0] SCP_WORD      = {K28_2, K27_7, K28_5, K28_5};
  localparam logic [31:0] ECP_WORD      = {K29_7, K30_7, K28_5, K28_5};
  localparam logic [31:0] CC_WORD       = {K23_7, K23_7, K23_7, K23_7};
  localparam logic [31:0] IDLE_RST_WORD = {K28_5, K28_5, K28_5, K28_5};

  // A set LFSR bit selects /A/ (K28.3), a clear bit selects /R/ (K28.0).
  function automatic logic [7:0] idle_sym(input logic sel);
    return sel ? K28_3 : K28_0;
  endfunction

endpackage

// File: rtl/idle_gen.sv
// Pseudo-random idle word source: 7-bit LFSR stepped only when an idle word
// is actually transmitted.
module idle_gen
  import aurora_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        advance,
  output logic [31:0] idle_word
);

  logic [6:0] r_lfsr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= 7'h7F;
    end else if (advance) begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end

  assign idle_word = {K28_5, idle_sym(r_lfsr[0]), idle_sym(r_lfsr[1]), idle_sym(r_lfsr[2])};

endmodule

// File: rtl/tx_symbol_gen.sv
// Aurora TX symbol generator: frame FSM, clock-compensation scheduler and the
// registered symbol/K-flag output stage.
module tx_symbol_gen
  import aurora_pkg::*;
#(
  parameter int CC_PERIOD = 5000,
  parameter int CC_LEN    = 3
)
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  ordered_sets_e            ordered_sets,
  input  logic [AXI_DATA_SIZE-1:0] data_in,
  output logic [31:0]              tx_data,
  output logic [3:0]               tx_charisk,
  output logic                     framing_err
);

  localparam int CNT_W = (CC_PERIOD > 1) ? $clog2(CC_PERIOD) : 1;
  localparam int REM_W = $clog2(CC_LEN + 1);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CC_PERIOD - 1);
  localparam logic [REM_W-1:0] REM_LOAD  = REM_W'(CC_LEN);

  frame_state_e     r_state;
  frame_state_e     w_state_next;
  logic [CNT_W-1:0] r_cc_cnt;
  logic [REM_W-1:0] r_cc_remain;
  logic [31:0]      r_tx_data;
  logic [3:0]       r_tx_charisk;
  logic             r_framing_err;

  logic [31:0]      w_idle_word;
  logic [31:0]      w_tx_data;
  logic [3:0]       w_tx_charisk;
  logic             w_framing_err;
  logic             w_cc_emit;
  logic             w_lfsr_adv;
  logic             w_cc_load;

  idle_gen u_idle_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (w_lfsr_adv),
    .idle_word (w_idle_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OUT_FRAME;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: every combinational output gets a default before any branch, so no
  // path can leave a value unassigned and infer a latch.
  always_comb begin
    w_state_next = r_state;
    unique case (ordered_sets)
      SCP:     w_state_next = IN_FRAME;
      ECP:     w_state_next = OUT_FRAME;
      default: w_state_next = r_state;
    endcase
  end

  // Frame traffic always wins; a pending CC sequence only consumes idle slots.
  always_comb begin
    w_tx_data     = IDLE_RST_WORD;
    w_tx_charisk  = 4'hF;
    w_framing_err = 1'b0;
    w_cc_emit     = 1'b0;
    w_lfsr_adv    = 1'b0;
    if (ordered_sets == SCP) begin
      w_tx_data     = SCP_WORD;
      w_framing_err = (r_state == IN_FRAME);
    end else if (ordered_sets == ECP) begin
      w_tx_data     = ECP_WORD;
      w_framing_err = (r_state == OUT_FRAME);
    end else if (ordered_sets == NONE && r_state == IN_FRAME) begin
      w_tx_data    = data_in;
      w_tx_charisk = 4'h0;
    end else if (r_cc_remain != '0) begin
      w_tx_data = CC_WORD;
      w_cc_emit = 1'b1;
    end else begin
      w_tx_data  = w_idle_word;
      w_lfsr_adv = 1'b1;
    end
  end

  // A request that lands while a sequence is still pending is dropped.
  assign w_cc_load = (r_cc_cnt == CNT_LAST) && (r_cc_remain == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc_cnt <= '0;
    end else if (r_cc_cnt == CNT_LAST) begin
      r_cc_cnt <= '0;
    end else begin
      r_cc_cnt <= r_cc_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cc_remain <= '0;
    end else if (w_cc_load) begin
      r_cc_remain <= REM_LOAD;
    end else if (w_cc_emit) begin
      r_cc_remain <= r_cc_remain - REM_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data     <= IDLE_RST_WORD;
      r_tx_charisk  <= 4'hF;
      r_framing_err <= 1'b0;
    end else begin
      r_tx_data     <= w_tx_data;
      r_tx_charisk  <= w_tx_charisk;
      r_framing_err <= w_framing_err;
    end
  end

  assign tx_data     = r_tx_data;
  assign tx_charisk  = r_tx_charisk;
  assign framing_err = r_framing_err;

endmodule

// File: tb/tb_tx_symbol_gen.sv
// Scoreboard bench for tx_symbol_gen: the driver queues the expected symbol
// for each input cycle, a free-running monitor compares one cycle later.
module tb_tx_symbol_gen;
  import aurora_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  ordered_sets_e ordered_sets = I;
  logic [31:0]   data_in = '0;
  logic [31:0]   tx_data;
  logic [3:0]    tx_charisk;
  logic          framing_err;

  tx_symbol_gen #(.CC_PERIOD(8), .CC_LEN(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ordered_sets (ordered_sets),
    .data_in      (data_in),
    .tx_data      (tx_data),
    .tx_charisk   (tx_charisk),
    .framing_err  (framing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] data;
    logic [3:0]  k;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got_d, input logic [3:0] got_k,
                       input logic got_e, input logic [31:0] exp_d, input logic [3:0] exp_k,
                       input logic exp_e);
    n_checks++;
    if (got_d === exp_d && got_k === exp_k && got_e === exp_e) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got data=%h k=%h err=%b, expected data=%h k=%h err=%b",
               tag, got_d, got_k, got_e, exp_d, exp_k, exp_e);
    end
  endtask

  // Apply one input cycle at a falling edge and queue its expected response.
  task automatic drive(input ordered_sets_e os, input logic [31:0] d, input string tag,
                       input logic [31:0] ed, input logic [3:0] ek, input logic ee);
    exp_t e;
    ordered_sets = os;
    data_in      = d;
    e.tag  = tag;
    e.data = ed;
    e.k    = ek;
    e.err  = ee;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Called at a falling edge; returns at the falling edge where reset releases.
  task automatic do_reset(input string tag);
    ordered_sets = I;
    data_in      = '0;
    rst_n        = 1'b0;
    #1;
    check({tag, " in reset"}, tx_data, tx_charisk, framing_err, 32'hBCBCBCBC, 4'hF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check(e.tag, tx_data, tx_charisk, framing_err, e.data, e.k, e.err);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  logic [31:0] t4_exp [23];

  initial begin : stimulus
    @(negedge clk);

    do_reset("t1");
    drive(NONE, 32'h99999999, "t1 idle0", 32'hBC7C7C7C, 4'hF, 1'b0);
    drive(NONE, 32'h99999999, "t1 idle1", 32'hBC1C7C7C, 4'hF, 1'b0);

    do_reset("t2");
    drive(SCP,  32'h0,        "t2 scp",  32'h5CFBBCBC, 4'hF, 1'b0);
    drive(NONE, 32'h11223344, "t2 d0",   32'h11223344, 4'h0, 1'b0);
    drive(NONE, 32'hAABBCCDD, "t2 d1",   32'hAABBCCDD, 4'h0, 1'b0);
    drive(ECP,  32'h0,        "t2 ecp",  32'hFDFEBCBC, 4'hF, 1'b0);
    drive(NONE, 32'h55555555, "t2 idle", 32'hBC7C7C7C, 4'hF, 1'b0);

    do_reset("t3");
    drive(SCP,  32'h0,        "t3 scp",  32'h5CFBBCBC, 4'hF, 1'b0);
    drive(NONE, 32'h01020304, "t3 d0",   32'h01020304, 4'h0, 1'b0);
    drive(I,    32'h0,        "t3 i",    32'hBC7C7C7C, 4'hF, 1'b0);
    drive(NONE, 32'h05060708, "t3 d1",   32'h05060708, 4'h0, 1'b0);
    drive(ECP,  32'h0,        "t3 ecp",  32'hFDFEBCBC, 4'hF, 1'b0);

    // Cycle n (1-based after release): CC loads at the edge of cycle 8 and 16.
    t4_exp = '{32'hBC7C7C7C, 32'hBC1C7C7C, 32'hBC1C1C7C, 32'hBC1C1C1C,
               32'hBC1C1C1C, 32'hBC1C1C1C, 32'hBC1C1C1C, 32'hBC7C1C1C,
               32'hF7F7F7F7, 32'hF7F7F7F7, 32'hF7F7F7F7, 32'hBC1C7C1C,
               32'hBC1C1C7C, 32'hBC1C1C1C, 32'hBC1C1C1C, 32'hBC1C1C1C,
               32'hF7F7F7F7, 32'h5CFBBCBC, 32'h12345678, 32'hFDFEBCBC,
               32'hF7F7F7F7, 32'hF7F7F7F7, 32'hBC7C1C1C};
    do_reset("t4");
    for (int c = 1; c <= 23; c++) begin
      case (c)
        18:      drive(SCP,  32'h0,        $sformatf("t4 c%0d", c), t4_exp[c-1], 4'hF, 1'b0);
        19:      drive(NONE, 32'h12345678, $sformatf("t4 c%0d", c), t4_exp[c-1], 4'h0, 1'b0);
        20:      drive(ECP,  32'h0,        $sformatf("t4 c%0d", c), t4_exp[c-1], 4'hF, 1'b0);
        default: drive(I,    32'h0,        $sformatf("t4 c%0d", c), t4_exp[c-1], 4'hF, 1'b0);
      endcase
    end

    do_reset("t5");
    drive(ECP,  32'h0,        "t5 ecp oof", 32'hFDFEBCBC, 4'hF, 1'b1);
    drive(NONE, 32'h77777777, "t5 idle",    32'hBC7C7C7C, 4'hF, 1'b0);
    drive(SCP,  32'h0,        "t5 scp0",    32'h5CFBBCBC, 4'hF, 1'b0);
    drive(SCP,  32'h0,        "t5 scp1",    32'h5CFBBCBC, 4'hF, 1'b1);
    drive(NONE, 32'hCAFEF00D, "t5 data",    32'hCAFEF00D, 4'h0, 1'b0);
    drive(ECP,  32'h0,        "t5 ecp",     32'hFDFEBCBC, 4'hF, 1'b0);

    do_reset("t6");
    drive(SCP,  32'h0,        "t6 scp",  32'h5CFBBCBC, 4'hF, 1'b0);
    drive(NONE, 32'h11111111, "t6 d0",   32'h11111111, 4'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6 async reset", tx_data, tx_charisk, framing_err, 32'hBCBCBCBC, 4'hF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(NONE, 32'hDEADBEEF, "t6 post idle0", 32'hBC7C7C7C, 4'hF, 1'b0);
    drive(NONE, 32'hDEADBEEF, "t6 post idle1", 32'hBC1C7C7C, 4'hF, 1'b0);

    repeat (2) @(negedge clk);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL scoreboard drain: %0d entries left, expected 0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
